// File: rtl/itrx_aib_phy_tx_lane_array.sv
// ---------------------------------------------------------------------------
// itrx_aib_phy_tx_lane_array
//
// TX lane array for an AIB-style PHY. Each logical channel captures a
// rising-phase and a falling-phase bit on ilaunch_clk and presents them as
// the clock-high / clock-low pad values (DDR), or repeats the rising-phase
// bit on both phases (SDR). A clock-forward test pattern can replace all
// synchronous data, and any channel can be switched to an async bypass.
// NCH channels are steered onto NCH+1 pads; one pad can be skipped for
// redundancy. A remap runs a QUIESCE -> REMAP -> SETTLE sequence during
// which every pad is held at 0, so the steering never changes while data
// is on the wire.
//
// Ports
//   ilaunch_clk  launch clock (only clock)
//   tx_rst       asynchronous active-high reset
//   tx_en        sync path enable (0 clears the capture registers)
//   ddr_mode     1 = DDR, 0 = SDR
//   pat_en       clock-forward test pattern enable
//   idat0/idat1  rising/falling-phase channel data
//   async_data   async bypass data, used where idat_selb[c] = 1
//   idat_selb    per-channel async select
//   redn_req     single-cycle remap request, redn_idx = failed pad index
//                (>= NCH disengages redundancy)
//   pad_hi/lo    per-pad values for clock-high / clock-low phase
//   redn_engage  per-pad shift select (pad j carries channel j-1)
//   redn_busy    remap sequence in progress
//   fsm_state    NORMAL=0, QUIESCE=1, REMAP=2, SETTLE=3
// ---------------------------------------------------------------------------
module itrx_aib_phy_tx_lane_array #(
    parameter int NCH  = 20,
    parameter int QCNT = 4,
    parameter int IW   = $clog2(NCH + 1)
) (
    input  logic           ilaunch_clk,
    input  logic           tx_rst,
    input  logic           tx_en,
    input  logic           ddr_mode,
    input  logic           pat_en,
    input  logic [NCH-1:0] idat0,
    input  logic [NCH-1:0] idat1,
    input  logic [NCH-1:0] async_data,
    input  logic [NCH-1:0] idat_selb,
    input  logic           redn_req,
    input  logic [IW-1:0]  redn_idx,
    output logic [NCH:0]   pad_hi,
    output logic [NCH:0]   pad_lo,
    output logic [NCH:0]   redn_engage,
    output logic           redn_busy,
    output logic [1:0]     fsm_state
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_REMAP   = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    localparam logic [3:0]    CNT_INIT = 4'(QCNT - 1);
    // Index value meaning "no pad skipped".
    localparam logic [IW-1:0] IDX_OFF  = IW'(NCH);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [IW-1:0]  pend_q, pend_d;
    logic [IW-1:0]  act_q, act_d;
    logic [NCH-1:0] q0_q, q0_d;
    logic [NCH-1:0] q1_q, q1_d;
    logic           tgl_q, tgl_d;
    logic           busy_q, busy_d;

    logic [NCH-1:0] sync_hi, sync_lo;
    logic [NCH-1:0] ch_hi, ch_lo;
    logic [NCH:0]   ext_hi, ext_lo, sh_hi, sh_lo;
    logic [NCH:0]   engage;
    logic [NCH:0]   map_hi, map_lo;

    // Next-state logic: capture path, pattern toggle, remap sequencer.
    always_comb begin
        q0_d    = tx_en ? idat0 : '0;
        q1_d    = tx_en ? idat1 : '0;
        tgl_d   = pat_en ? ~tgl_q : 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        act_d   = act_q;
        unique case (state_q)
            ST_NORMAL: begin
                // The index is latched here so later redn_idx changes are inert.
                if (redn_req) begin
                    state_d = ST_QUIESCE;
                    cnt_d   = CNT_INIT;
                    pend_d  = redn_idx;
                end
            end
            ST_QUIESCE: begin
                if (cnt_q == 4'd0) state_d = ST_REMAP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_REMAP: begin
                act_d   = pend_q;
                state_d = ST_SETTLE;
                cnt_d   = CNT_INIT;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) state_d = ST_NORMAL;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_NORMAL;
        endcase
        busy_d = (state_d != ST_NORMAL);
    end

    always_ff @(posedge ilaunch_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
            pend_q  <= IDX_OFF;
            act_q   <= IDX_OFF;
            q0_q    <= '0;
            q1_q    <= '0;
            tgl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            tgl_q   <= tgl_d;
            busy_q  <= busy_d;
        end
    end

    // Channel values, then channel-to-pad steering.
    always_comb begin
        if (pat_en) begin
            sync_hi = ddr_mode ? '1 : {NCH{tgl_q}};
            sync_lo = ddr_mode ? '0 : {NCH{tgl_q}};
        end else begin
            sync_hi = q0_q;
            sync_lo = ddr_mode ? q1_q : q0_q;
        end
        ch_hi = (idat_selb & async_data) | (~idat_selb & sync_hi);
        ch_lo = (idat_selb & async_data) | (~idat_selb & sync_lo);

        // ext: pad j carries channel j (spare pad reads 0).
        // sh:  pad j carries channel j-1 (pad 0 reads 0).
        ext_hi = {1'b0, ch_hi};
        ext_lo = {1'b0, ch_lo};
        sh_hi  = {ch_hi, 1'b0};
        sh_lo  = {ch_lo, 1'b0};

        for (int j = 0; j <= NCH; j++) begin
            engage[j] = (act_q < IDX_OFF) && (IW'(j) > act_q);
            if (IW'(j) == act_q) begin
                map_hi[j] = 1'b0;
                map_lo[j] = 1'b0;
            end else if (engage[j]) begin
                map_hi[j] = sh_hi[j];
                map_lo[j] = sh_lo[j];
            end else begin
                map_hi[j] = ext_hi[j];
                map_lo[j] = ext_lo[j];
            end
        end

        // All pads, async ones included, are quiet for the whole remap window.
        if (state_q != ST_NORMAL) begin
            pad_hi = '0;
            pad_lo = '0;
        end else begin
            pad_hi = map_hi;
            pad_lo = map_lo;
        end
    end

    assign redn_engage = engage;
    assign redn_busy   = busy_q;
    assign fsm_state   = state_q;

endmodule

// File: doc/itrx_aib_phy_tx_lane_array.md
ITRX_AIB_PHY_TX_LANE_ARRAY -- requirements
Module: itrx_aib_phy_tx_lane_array

Interface
REQ-001 SHALL have parameters: NCH, 20, number of logical TX channels; QCNT, 4, quiesce/settle length in cycles (1..15); IW, $clog2(NCH+1), width of redundancy index.
REQ-002 SHALL have ports: ilaunch_clk  in  1  TX launch clock, sole clock; tx_rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: tx_en  in  1  sync path enable; ddr_mode  in  1  1=DDR, 0=SDR; pat_en  in  1  clock-forward test pattern enable.
REQ-004 SHALL have ports: idat0  in  NCH  rising-phase data; idat1  in  NCH  falling-phase data; async_data  in  NCH  async bypass data; idat_selb  in  NCH  per-channel async select (1=async).
REQ-005 SHALL have ports: redn_req  in  1  single-cycle remap request; redn_idx  in  IW  failed pad index (>=NCH means disengage redundancy).
REQ-006 SHALL have ports: pad_hi  out  NCH+1  value for clock-high phase per pad; pad_lo  out  NCH+1  value for clock-low phase per pad; redn_engage  out  NCH+1  per-pad shift select; redn_busy  out  1  remap in progress; fsm_state  out  2  current state.

Function
REQ-007 SHALL register idat0 into q0[NCH] and idat1 into q1[NCH] on rising ilaunch_clk when tx_en=1; tx_en=0 SHALL clear q0/q1 next edge.
REQ-008 Sync channel c SHALL present hi=q0[c], lo=(ddr_mode ? q1[c] : q0[c]); latency idat->pad = 1 cycle.
REQ-009 pat_en=1 SHALL replace all sync channel data: DDR hi=1, lo=0; SDR hi=lo=tgl, tgl a flop toggling every cycle (reset 0, held 0 when pat_en=0).
REQ-010 Channel with idat_selb[c]=1 SHALL drive hi=lo=async_data[c] combinationally, ignoring tx_en, pat_en, q regs.
REQ-011 Mapping with active index k<NCH: pad j<k carries channel j; pad k drives 0; pad j>k carries channel j-1; redn_engage[j]=1 for j>k, else 0.
REQ-012 Mapping disengaged (k>=NCH): pad j<NCH carries channel j; spare pad NCH drives 0; redn_engage all 0.
REQ-013 FSM states NORMAL(0), QUIESCE(1), REMAP(2), SETTLE(3); redn_busy=1 whenever state!=NORMAL.
REQ-014 NORMAL: redn_req=1 -> QUIESCE next cycle, counter loaded with QCNT-1.
REQ-015 QUIESCE: all pad_hi/pad_lo forced 0 (including async channels); counter 0 -> REMAP, else decrement.
REQ-016 REMAP: one cycle; active index register loaded from redn_idx sampled at the original redn_req cycle; pads forced 0; -> SETTLE with counter QCNT-1.
REQ-017 SETTLE: pads forced 0, new mapping and redn_engage already visible; counter 0 -> NORMAL.
REQ-018 redn_req while redn_busy=1 SHALL be ignored; redn_idx changes after request cycle SHALL have no effect.
REQ-019 Total remap window SHALL be exactly 2*QCNT+1 cycles of forced-0 pads after the request cycle.
REQ-020 Requesting the already-active index SHALL still execute the full sequence.

Reset
REQ-021 tx_rst=1 SHALL asynchronously clear q0, q1, tgl, counter, active index (set to NCH, disengaged), state=NORMAL; pads 0 except async-selected channels; redn_engage 0; redn_busy 0.
REQ-022 Reset asserted mid-remap SHALL abort to NORMAL with disengaged mapping; previous active index discarded.
REQ-023 First capture after deassertion occurs on the first rising edge with tx_rst=0.

Verification
REQ-024 NCH=4, DDR, idat0=4'b1010, idat1=4'b0101, disengaged -> one cycle later pad_hi=5'b01010, pad_lo=5'b00101.
REQ-025 redn_req with redn_idx=1, QCNT=4 -> redn_busy high 9 cycles, pads 0 throughout; after: pad_hi=5'b10100 for same data, redn_engage=5'b11100.
REQ-026 SDR, pat_en=1 -> all sync pads hi=lo alternating 0,1,0,1 per cycle; DDR pat_en=1 -> hi=1, lo=0 constant.
REQ-027 idat_selb=4'b0001, async_data toggled, tx_en=0 -> pad0 follows async_data same cycle; remaining pads 0.
REQ-028 tx_rst asserted during SETTLE after remap to index 2 -> immediate state NORMAL, redn_busy 0, redn_engage 0, pads 0.
REQ-029 Second redn_req during QUIESCE with different index -> ignored; final mapping uses first index.
